// File: rtl/axi_pkg.sv
// Shared AXI read-address types and default bus widths.
// Widths can be overridden by defining the AXI_* macros before this file.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_pkg;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_arb_state_e;

    typedef logic mst_idx_t;

    localparam logic [3:0] TAG_M0_DEF = 4'h1;
    localparam logic [3:0] TAG_M1_DEF = 4'h2;

    typedef struct packed {
        logic [`AXI_IDS_BITS-1:0]  id;
        logic [`AXI_ADDR_BITS-1:0] addr;
        logic [`AXI_LEN_BITS-1:0]  len;
        logic [`AXI_SIZE_BITS-1:0] size;
        logic [1:0]                burst;
    } ar_chan_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant: the requester named by ptr wins, else the other.
// Pointer state is owned by the instantiating block.
module rr_arb2
    import axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  mst_idx_t   ptr,
    output logic [1:0] gnt,
    output mst_idx_t   gnt_idx
);

    mst_idx_t alt;

    assign alt = ~ptr;

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = ptr;
        if (en && req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (en && req[alt]) begin
            gnt[alt] = 1'b1;
            gnt_idx  = alt;
        end
    end

endmodule

// File: rtl/ar_arbiter.sv
// Two-master AR arbiter feeding a registered, ID-tagged AR channel downstream.
// Define AR_ARB_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module ar_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] TAG_M0 = TAG_M0_DEF,
    parameter logic [3:0] TAG_M1 = TAG_M1_DEF
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]                ARBURST_M0,
    input  logic                      ARVALID_M0,
    output logic                      ARREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]                ARBURST_M1,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]  ARID,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY
);

    ar_arb_state_e state_q, state_d;
    ar_chan_t      ar_q, ar_d;
    logic          can_load;
    logic [1:0]    gnt;
    mst_idx_t      gnt_idx;
    mst_idx_t      rr_ptr;

    // Reset also gates the accept pulses so nothing is taken while held.
    assign can_load = ~ARESET & ((state_q == AR_IDLE) | ARREADY);

    rr_arb2 u_rr_arb2 (
        .req     ({ARVALID_M1, ARVALID_M0}),
        .en      (can_load),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef AR_ARB_FIXED_PRIO_EN
    assign rr_ptr = 1'b0;
`else
    mst_idx_t rr_ptr_q, rr_ptr_d;

    assign rr_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|gnt) rr_ptr_d = ~gnt_idx;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign ARREADY_M0 = gnt[0];
    assign ARREADY_M1 = gnt[1];

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        if (can_load) begin
            if (|gnt) begin
                state_d = AR_SEND;
                if (gnt_idx) begin
                    ar_d.id    = {TAG_M1, ARID_M1};
                    ar_d.addr  = ARADDR_M1;
                    ar_d.len   = ARLEN_M1;
                    ar_d.size  = ARSIZE_M1;
                    ar_d.burst = ARBURST_M1;
                end else begin
                    ar_d.id    = {TAG_M0, ARID_M0};
                    ar_d.addr  = ARADDR_M0;
                    ar_d.len   = ARLEN_M0;
                    ar_d.size  = ARSIZE_M0;
                    ar_d.burst = ARBURST_M0;
                end
            end else begin
                state_d = AR_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= AR_IDLE;
            ar_q    <= '0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
        end
    end

    assign ARVALID = (state_q == AR_SEND);
    assign ARID    = ar_q.id;
    assign ARADDR  = ar_q.addr;
    assign ARLEN   = ar_q.len;
    assign ARSIZE  = ar_q.size;
    assign ARBURST = ar_q.burst;

endmodule

// File: tb/tb_ar_arbiter.sv
// Randomized scoreboard bench for ar_arbiter with directed reset,
// latency, contention, backpressure and slow-slave scenarios.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_ar_arbiter;

    localparam int IW = `AXI_ID_BITS;
    localparam int AW = `AXI_ADDR_BITS;
    localparam int LW = `AXI_LEN_BITS;
    localparam int SW = `AXI_SIZE_BITS;
    localparam int PW = IW + 4 + AW + LW + SW + 2;
    localparam logic [3:0] T0 = 4'h1;
    localparam logic [3:0] T1 = 4'h2;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic rdy;

    logic [IW-1:0] sid[2];
    logic [AW-1:0] saddr[2];
    logic [LW-1:0] slen[2];
    logic [SW-1:0] ssize[2];
    logic [1:0]    sburst[2];
    logic          sv[2];

    logic                ARREADY_M0, ARREADY_M1, ARVALID;
    logic [IW+3:0]       ARID;
    logic [AW-1:0]       ARADDR;
    logic [LW-1:0]       ARLEN;
    logic [SW-1:0]       ARSIZE;
    logic [1:0]          ARBURST;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] expq[$];
    int occ, pri, acc;

    logic [PW-1:0] prev;
    logic [PW-1:0] cur;
    logic [PW-1:0] e;
    logic          hold = 1'b0;

    always #5 ACLK = ~ACLK;

    ar_arbiter dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .ARID_M0    (sid[0]),
        .ARADDR_M0  (saddr[0]),
        .ARLEN_M0   (slen[0]),
        .ARSIZE_M0  (ssize[0]),
        .ARBURST_M0 (sburst[0]),
        .ARVALID_M0 (sv[0]),
        .ARREADY_M0 (ARREADY_M0),
        .ARID_M1    (sid[1]),
        .ARADDR_M1  (saddr[1]),
        .ARLEN_M1   (slen[1]),
        .ARSIZE_M1  (ssize[1]),
        .ARBURST_M1 (sburst[1]),
        .ARVALID_M1 (sv[1]),
        .ARREADY_M1 (ARREADY_M1),
        .ARID       (ARID),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARBURST    (ARBURST),
        .ARVALID    (ARVALID),
        .ARREADY    (rdy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic new_req(input int m);
        sv[m]     = 1'b1;
        sid[m]    = IW'($urandom);
        saddr[m]  = AW'($urandom);
        slen[m]   = LW'($urandom);
        ssize[m]  = SW'($urandom);
        sburst[m] = 2'($urandom);
    endtask

    // A master holds its request until accepted, then may issue another.
    task automatic rand_master(input int m, input int pct);
        if (acc == m || !sv[m]) begin
            if (int'($urandom_range(99)) < pct) new_req(m);
            else sv[m] = 1'b0;
        end
    endtask

    // Reference: one output slot, freed by downstream acceptance; the
    // preferred master wins a free slot and then yields preference.
    task automatic step();
        int g;
        bit can;
        @(negedge ACLK);
        chk("arvalid", 64'(ARVALID), 64'(occ != 0));
        can = (occ == 0) || rdy;
        g = -1;
        if (can) begin
            if (sv[pri]) g = pri;
            else if (sv[1-pri]) g = 1 - pri;
        end
        chk("arready_m0", 64'(ARREADY_M0), 64'(g == 0));
        chk("arready_m1", 64'(ARREADY_M1), 64'(g == 1));
        if (g >= 0) begin
            expq.push_back({(g == 1) ? T1 : T0, sid[g], saddr[g],
                            slen[g], ssize[g], sburst[g]});
            occ = 1;
`ifndef AR_ARB_FIXED_PRIO_EN
            pri = 1 - g;
`endif
        end else if (can) begin
            occ = 0;
        end
        acc = g;
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: pop on each downstream handshake; check hold stability.
    initial begin
        forever begin
            @(negedge ACLK);
            cur = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
            if (ARESET) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    chk("stable", 64'({ARVALID, cur}), 64'({1'b1, prev}));
                if (ARVALID && rdy) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected: got %0h want none", cur);
                    end else begin
                        e = expq.pop_front();
                        chk("payload", 64'(cur), 64'(e));
                    end
                end
                hold = ARVALID && !rdy;
                prev = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            sv[m] = 1'b0; sid[m] = '0; saddr[m] = '0;
            slen[m] = '0; ssize[m] = '0; sburst[m] = '0;
        end
        rdy = 1'b0;
        occ = 0; pri = 0; acc = -1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_arid", 64'(ARID), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);

        // Single M1 request: accept, present next cycle, drop after.
        sv[1] = 1'b1; sid[1] = IW'(5); saddr[1] = AW'(32'h1_0040);
        slen[1] = '0; ssize[1] = SW'(2); sburst[1] = 2'b01;
        rdy = 1'b1;
        step();
        chk("t2_acc", 64'(acc), 64'(1));
        sv[1] = 1'b0;
        chk("t2_arvalid", 64'(ARVALID), 64'd1);
        chk("t2_arid", 64'(ARID), 64'(8'h25));
        step();
        chk("t2_drop", 64'(ARVALID), 64'd0);

        // Contention: both masters always valid.
        new_req(0); new_req(1);
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef AR_ARB_FIXED_PRIO_EN
            chk("t3_order", 64'(acc), 64'(0));
`else
            chk("t3_order", 64'(acc), 64'(i % 2));
`endif
            new_req(acc);
        end

        // Backpressure with the slot full.
        sv[1] = 1'b0; new_req(0); rdy = 1'b0;
        repeat (5) begin
            step();
            chk("t4_block", 64'(acc), -64'sd1);
        end
        rdy = 1'b1;
        step();
        chk("t4_accept", 64'(acc), 64'(0));
        sv[0] = 1'b0;
        step();

        // Out-of-map request held until a slow default slave accepts.
        new_req(1); saddr[1] = AW'(32'h2_0000); rdy = 1'b1;
        step();
        sv[1] = 1'b0; rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        step();
        step();
        chk("t5_free", 64'(ARVALID), 64'd0);

        // Reset while a request is held.
        new_req(0); rdy = 1'b0;
        step();
        new_req(0); new_req(1);
        #2 ARESET = 1'b1;
        #1;
        chk("t1_arvalid", 64'(ARVALID), 64'd0);
        chk("t1_arid", 64'(ARID), 64'd0);
        chk("t1_rdy_m0", 64'(ARREADY_M0), 64'd0);
        chk("t1_rdy_m1", 64'(ARREADY_M1), 64'd0);
        expq.delete();
        occ = 0; pri = 0; acc = -1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        rdy = 1'b1;
        step();
        chk("t1_first_m0", 64'(acc), 64'(0));

        // Random traffic, then saturated traffic.
        for (int i = 0; i < 400; i++) begin
            rand_master(0, 50);
            rand_master(1, 50);
            rdy = ($urandom_range(99) < 60);
            step();
        end
        for (int i = 0; i < 60; i++) begin
            rand_master(0, 100);
            rand_master(1, 100);
            rdy = ($urandom_range(99) < 85);
            step();
        end

        sv[0] = 1'b0; sv[1] = 1'b0; rdy = 1'b1;
        repeat (4) step();
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
